gpr_wb_scheduler: RTL and testbench

GPR_WB_SCHEDULER -- requirements
Module: gpr_wb_scheduler

---
 rtl/gpr_wb_scheduler.sv | 161 ++++++++++++++++
 tb/tb_gpr_wb_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_wb_scheduler.sv
// gpr_wb_scheduler
//   Arbitrates the single GPR write port between the in-order pipeline and a
//   multi-cycle multiply unit. A late multiply result is parked in a one-entry
//   buffer and written whenever the pipeline leaves the write port free. If it
//   loses AGE_LIMIT consecutive grants to the pipeline, it is forced through
//   and the pipeline is stalled for one cycle.
//
// Ports
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_flush            synchronous discard of the buffered late result
//   i_pipe_valid/waddr/sel   pipeline write request (sel = GPR_W_SEL code)
//   i_late_valid/waddr/data  late result offer; accepted when o_late_ready
//   o_late_ready       buffer empty and able to accept a late result
//   o_pipe_stall       pipeline write deferred this cycle (request is held)
//   o_gpr_we/waddr     GPR write enable and address
//   o_wdata_sel        GPR write-data mux select
//   o_mul_data         buffered late value, feeds the mux MUL input
module gpr_wb_scheduler #(
  parameter int AGE_LIMIT = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_pipe_valid,
  input  logic [4:0]  i_pipe_waddr,
  input  logic [2:0]  i_pipe_sel,
  input  logic        i_late_valid,
  input  logic [4:0]  i_late_waddr,
  input  logic [31:0] i_late_data,
  output logic        o_late_ready,
  output logic        o_pipe_stall,
  output logic        o_gpr_we,
  output logic [4:0]  o_gpr_waddr,
  output logic [2:0]  o_wdata_sel,
  output logic [31:0] o_mul_data
);

  // Shared GPR write-data source encodings
  localparam logic [2:0] GPR_W_SEL_ALU = 3'd0;
  localparam logic [2:0] GPR_W_SEL_MEM = 3'd1;
  localparam logic [2:0] GPR_W_SEL_PC  = 3'd2;
  localparam logic [2:0] GPR_W_SEL_MUL = 3'd3;

  localparam logic [2:0] AGE_LIM = 3'(AGE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  age;
  logic [4:0]  buf_waddr;
  logic [31:0] buf_data;

  logic        pipe_grant;
  logic        late_grant;
  logic        stall;
  logic        go_idle;
  logic        go_force;
  logic [2:0]  age_inc;

  // Grant decision and next-state hints, purely from state and inputs
  always_comb begin
    pipe_grant = 1'b0;
    late_grant = 1'b0;
    stall      = 1'b0;
    go_idle    = 1'b0;
    go_force   = 1'b0;
    age_inc    = {1'b0, age} + 3'd1;
    case (state)
      IDLE: begin
        pipe_grant = i_pipe_valid;
      end
      PEND: begin
        if (i_pipe_valid) begin
          pipe_grant = 1'b1;
          // A newer pipeline write to the same register makes the buffered value dead
          if (i_pipe_waddr == buf_waddr) begin
            go_idle = 1'b1;
          end else if (age_inc == AGE_LIM) begin
            go_force = 1'b1;
          end else begin
            go_force = 1'b0;
          end
        end else begin
          // A flush in the drain cycle discards the entry instead of writing it
          late_grant = ~i_flush;
          go_idle    = 1'b1;
        end
      end
      FORCE: begin
        late_grant = ~i_flush;
        stall      = i_pipe_valid;
        go_idle    = 1'b1;
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase
  end

  // Write-port outputs; reset forces all handshake and enable outputs low
  assign o_late_ready = i_rst_n & (state == IDLE);
  assign o_pipe_stall = i_rst_n & stall;
  assign o_gpr_we     = i_rst_n & ((pipe_grant & (i_pipe_waddr != 5'd0)) |
                                   (late_grant & (buf_waddr != 5'd0)));
  assign o_gpr_waddr  = late_grant ? buf_waddr : i_pipe_waddr;
  assign o_wdata_sel  = late_grant ? GPR_W_SEL_MUL : i_pipe_sel;
  assign o_mul_data   = buf_data;

  // FSM, age counter and late buffer; flush overrides everything but reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      age       <= 2'd0;
      buf_waddr <= 5'd0;
      buf_data  <= 32'd0;
    end else if (i_flush) begin
      state     <= IDLE;
      age       <= 2'd0;
      buf_waddr <= 5'd0;
      buf_data  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (i_late_valid) begin
            state     <= PEND;
            age       <= 2'd0;
            buf_waddr <= i_late_waddr;
            buf_data  <= i_late_data;
          end else begin
            state <= IDLE;
          end
        end
        PEND: begin
          if (go_idle) begin
            state <= IDLE;
            age   <= 2'd0;
          end else if (go_force) begin
            state <= FORCE;
            age   <= age_inc[1:0];
          end else begin
            state <= PEND;
            age   <= age_inc[1:0];
          end
        end
        FORCE: begin
          state <= IDLE;
          age   <= 2'd0;
        end
        default: begin
          state <= IDLE;
          age   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpr_wb_scheduler.sv
// Testbench for gpr_wb_scheduler: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_gpr_wb_scheduler;

  localparam logic [2:0] SEL_ALU = 3'd0;
  localparam logic [2:0] SEL_MEM = 3'd1;
  localparam logic [2:0] SEL_MUL = 3'd3;
  localparam int AGE_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n, flush, pv, lv;
  logic [4:0]  pwa, lwa;
  logic [2:0]  psel;
  logic [31:0] ld;

  logic        late_ready, pipe_stall, gpr_we;
  logic [4:0]  gpr_waddr;
  logic [2:0]  wdata_sel;
  logic [31:0] mul_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  wa;
    logic [31:0] d;
  } late_t;

  late_t q[$];
  int    lost = 0;
  logic  m_stall = 1'b0;

  gpr_wb_scheduler #(.AGE_LIMIT(AGE_LIMIT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_pipe_valid(pv), .i_pipe_waddr(pwa), .i_pipe_sel(psel),
    .i_late_valid(lv), .i_late_waddr(lwa), .i_late_data(ld),
    .o_late_ready(late_ready), .o_pipe_stall(pipe_stall), .o_gpr_we(gpr_we),
    .o_gpr_waddr(gpr_waddr), .o_wdata_sel(wdata_sel), .o_mul_data(mul_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, let outputs settle,
  // compare against the model, then advance the model past the rising edge.
  task automatic cyc(input logic r, input logic f, input logic p, input logic [4:0] pa,
                     input logic [2:0] ps, input logic l, input logic [4:0] la,
                     input logic [31:0] d);
    logic gp, gl, e_rdy, e_stall, e_we, pop;
    late_t head;
    @(negedge clk);
    rst_n = r; flush = f; pv = p; pwa = pa; psel = ps; lv = l; lwa = la; ld = d;
    #1;
    gp = 1'b0; gl = 1'b0; e_stall = 1'b0; pop = 1'b0; e_rdy = 1'b0;
    head.wa = 5'd0; head.d = 32'd0;
    if (!r) begin
      q.delete();
      lost = 0;
    end else begin
      e_rdy = (q.size() == 0);
      if (q.size() != 0) head = q[0];
      if (q.size() == 0) begin
        gp = p;
      end else if (lost == AGE_LIMIT) begin
        gl = !f; e_stall = p; pop = 1'b1;
      end else if (p) begin
        gp = 1'b1; lost++; pop = (pa == head.wa);
      end else begin
        gl = !f; pop = 1'b1;
      end
    end
    e_we = (gp && pa != 5'd0) || (gl && head.wa != 5'd0);
    chk("late_ready", {31'd0, late_ready}, {31'd0, e_rdy});
    chk("pipe_stall", {31'd0, pipe_stall}, {31'd0, e_stall});
    chk("gpr_we", {31'd0, gpr_we}, {31'd0, e_we});
    if (gp) begin
      chk("pipe_waddr", {27'd0, gpr_waddr}, {27'd0, pa});
      chk("pipe_sel", {29'd0, wdata_sel}, {29'd0, ps});
    end
    if (gl) begin
      chk("late_waddr", {27'd0, gpr_waddr}, {27'd0, head.wa});
      chk("late_sel", {29'd0, wdata_sel}, {29'd0, SEL_MUL});
    end
    if (!r || q.size() != 0) chk("mul_data", mul_data, head.d);
    m_stall = e_stall;
    if (pop) void'(q.pop_front());
    if (f) q.delete();
    if (r && e_rdy && l && !f) begin
      late_t e;
      e.wa = la; e.d = d;
      q.push_back(e);
      lost = 0;
    end
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 1'b0, 5'd0, SEL_ALU, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic offer(input logic [4:0] la, input logic [31:0] d);
    cyc(1'b1, 1'b0, 1'b0, 5'd0, SEL_ALU, 1'b1, la, d);
  endtask

  initial begin
    logic        r_p, r_f, r_l, r_r;
    logic [4:0]  r_pa;
    logic [2:0]  r_ps;
    rst_n = 1'b0; flush = 1'b0; pv = 1'b0; pwa = 5'd0; psel = 3'd0;
    lv = 1'b0; lwa = 5'd0; ld = 32'd0;

    // Reset held with active inputs: nothing leaks through
    cyc(1'b0, 1'b0, 1'b1, 5'd3, SEL_ALU, 1'b1, 5'd4, 32'h1111_2222);
    chk("rst_we", {31'd0, gpr_we}, 32'd0);
    chk("rst_ready", {31'd0, late_ready}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, SEL_ALU, 1'b0, 5'd0, 32'd0);

    // Pipeline write right after reset release
    cyc(1'b1, 1'b0, 1'b1, 5'd5, SEL_ALU, 1'b0, 5'd0, 32'd0);
    chk("d1_we", {31'd0, gpr_we}, 32'd1);
    chk("d1_waddr", {27'd0, gpr_waddr}, 32'd5);
    chk("d1_ready", {31'd0, late_ready}, 32'd1);

    // Late result drains while the pipeline is idle
    offer(5'd9, 32'hDEAD_BEEF);
    idle();
    chk("d2_ready", {31'd0, late_ready}, 32'd0);
    chk("d2_we", {31'd0, gpr_we}, 32'd1);
    chk("d2_waddr", {27'd0, gpr_waddr}, 32'd9);
    chk("d2_sel", {29'd0, wdata_sel}, {29'd0, SEL_MUL});
    chk("d2_data", mul_data, 32'hDEAD_BEEF);
    idle();
    chk("d2_ready_after", {31'd0, late_ready}, 32'd1);

    // Starved late result is forced after AGE_LIMIT lost grants
    offer(5'd12, 32'h0BAD_F00D);
    for (int i = 1; i <= AGE_LIMIT; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 5'(i), SEL_ALU, 1'b0, 5'd0, 32'd0);
      chk("d3_pipe_waddr", {27'd0, gpr_waddr}, i);
    end
    cyc(1'b1, 1'b0, 1'b1, 5'd20, SEL_MEM, 1'b0, 5'd0, 32'd0);
    chk("d3_force_stall", {31'd0, pipe_stall}, 32'd1);
    chk("d3_force_waddr", {27'd0, gpr_waddr}, 32'd12);
    cyc(1'b1, 1'b0, 1'b1, 5'd20, SEL_MEM, 1'b0, 5'd0, 32'd0);
    chk("d3_held_waddr", {27'd0, gpr_waddr}, 32'd20);
    chk("d3_held_stall", {31'd0, pipe_stall}, 32'd0);

    // Pipeline write to the buffered register kills the late entry
    offer(5'd7, 32'h7777_7777);
    cyc(1'b1, 1'b0, 1'b1, 5'd7, SEL_MEM, 1'b0, 5'd0, 32'd0);
    chk("d4_sel", {29'd0, wdata_sel}, {29'd0, SEL_MEM});
    idle();
    chk("d4_no_write", {31'd0, gpr_we}, 32'd0);
    chk("d4_ready", {31'd0, late_ready}, 32'd1);

    // Late result to $0 drains silently
    offer(5'd0, 32'h0000_1234);
    idle();
    chk("d5_we", {31'd0, gpr_we}, 32'd0);
    idle();
    chk("d5_ready", {31'd0, late_ready}, 32'd1);

    // Reset during PEND discards the buffer
    offer(5'd11, 32'hCAFE_0011);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, SEL_ALU, 1'b0, 5'd0, 32'd0);
    chk("d6_we_rst", {31'd0, gpr_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 5'd0, SEL_ALU, 1'b0, 5'd0, 32'd0);
    idle();
    chk("d6_ready", {31'd0, late_ready}, 32'd1);
    chk("d6_we", {31'd0, gpr_we}, 32'd0);

    // Flush in PEND keeps the pipeline grant; flush beats a late handshake
    offer(5'd13, 32'h1313_1313);
    cyc(1'b1, 1'b1, 1'b1, 5'd6, SEL_ALU, 1'b0, 5'd0, 32'd0);
    chk("d7_pipe_we", {31'd0, gpr_we}, 32'd1);
    cyc(1'b1, 1'b1, 1'b0, 5'd0, SEL_ALU, 1'b1, 5'd14, 32'h1414_1414);
    idle();
    chk("d7_dropped", {31'd0, late_ready}, 32'd1);

    // Randomized traffic; a stalled pipeline request is held
    r_p = 1'b0; r_pa = 5'd0; r_ps = SEL_ALU;
    for (int n = 0; n < 600; n++) begin
      if (!m_stall) begin
        r_p  = ($urandom_range(0, 9) < 6);
        r_pa = 5'($urandom_range(0, 7));
        r_ps = 3'($urandom_range(0, 2));
      end
      r_r = ($urandom_range(0, 59) != 0);
      r_f = ($urandom_range(0, 19) == 0);
      r_l = ($urandom_range(0, 2) == 0);
      cyc(r_r, r_f, r_p, r_pa, r_ps, r_l, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
